// File: rtl/char_scan.sv
// Character buffer scanner: walks a ROWS x COLS character buffer in raster order and
// streams each code with its row/column through a small output FIFO under ready/valid.
module char_scan #(
  parameter int COLS  = 160,
  parameter int ROWS  = 64,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] r_row,
  output logic [7:0] r_col,
  input  logic [7:0] a_out,
  output logic [7:0] ch_out,
  output logic [7:0] ch_row,
  output logic [7:0] ch_col,
  output logic       eol,
  output logic       eof,
  output logic       ch_valid,
  input  logic       ch_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam logic [7:0]    LAST_COL = 8'(COLS - 1);
  localparam logic [7:0]    LAST_ROW = 8'(ROWS - 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     prow_q, prow_d, pcol_q, pcol_d;
  logic [7:0]     r_row_q, r_row_d, r_col_q, r_col_d;
  logic           sta_q, sta_d;
  logic           stb_q;
  logic [7:0]     stb_row_q, stb_col_q;
  logic [7:0]     mem_ch_q  [DEPTH];
  logic [7:0]     mem_row_q [DEPTH];
  logic [7:0]     mem_col_q [DEPTH];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [7:0]     ch_out_q, ch_out_d, ch_row_q, ch_row_d, ch_col_q, ch_col_d;
  logic           eol_q, eol_d, eof_q, eof_d;
  logic           ch_valid_q, ch_valid_d;
  logic           busy_q;
  logic           frame_done_q, frame_done_d;

  logic           pop_s, push_s, issue_s, last_s;
  logic [7:0]     cur_row_s, cur_col_s;
  logic [CW1-1:0] credit_s;
  logic [7:0]     head_ch_s, head_row_s, head_col_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      ptr_inc = PW'(0);
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  assign pop_s  = ch_valid_q & ch_ready;
  assign push_s = stb_q;

  // Occupancy the FIFO would reach if every outstanding read landed, after this cycle's pop.
  assign credit_s = CW1'(count_q) + CW1'(sta_q) + CW1'(stb_q) - CW1'(pop_s);

  // Frame sequencing, issue pointer and read address.
  always_comb begin
    state_d      = state_q;
    prow_d       = prow_q;
    pcol_d       = pcol_q;
    r_row_d      = r_row_q;
    r_col_d      = r_col_q;
    sta_d        = 1'b0;
    frame_done_d = 1'b0;
    issue_s      = 1'b0;
    if (state_q == S_IDLE) begin
      cur_row_s = 8'd0;
      cur_col_s = 8'd0;
    end else begin
      cur_row_s = prow_q;
      cur_col_s = pcol_q;
    end
    last_s = (cur_row_s == LAST_ROW) && (cur_col_s == LAST_COL);
    case (state_q)
      S_IDLE:  issue_s = start;
      S_RUN:   issue_s = (credit_s < CW1'(DEPTH));
      S_DRAIN: begin
        if ((count_q == CW'(0)) && !sta_q && !stb_q) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (issue_s) begin
      r_row_d = cur_row_s;
      r_col_d = cur_col_s;
      sta_d   = 1'b1;
      if (cur_col_s == LAST_COL) begin
        pcol_d = 8'd0;
        prow_d = cur_row_s + 8'd1;
      end else begin
        pcol_d = cur_col_s + 8'd1;
        prow_d = cur_row_s;
      end
      state_d = last_s ? S_DRAIN : S_RUN;
    end else begin
      sta_d = 1'b0;
    end
  end

  // FIFO pointers and the registered head; a push into an empty slot at the head is bypassed.
  always_comb begin
    count_d = count_q + CW'(push_s) - CW'(pop_s);
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (push_s && (rd_ptr_d == wr_ptr_q)) begin
      head_ch_s  = a_out;
      head_row_s = stb_row_q;
      head_col_s = stb_col_q;
    end else begin
      head_ch_s  = mem_ch_q[rd_ptr_d];
      head_row_s = mem_row_q[rd_ptr_d];
      head_col_s = mem_col_q[rd_ptr_d];
    end
    ch_valid_d = (count_d != CW'(0));
    if (ch_valid_d) begin
      ch_out_d = head_ch_s;
      ch_row_d = head_row_s;
      ch_col_d = head_col_s;
      eol_d    = (head_col_s == LAST_COL);
      eof_d    = (head_col_s == LAST_COL) && (head_row_s == LAST_ROW);
    end else begin
      ch_out_d = ch_out_q;
      ch_row_d = ch_row_q;
      ch_col_d = ch_col_q;
      eol_d    = eol_q;
      eof_d    = eof_q;
    end
  end

  // Control, read pipeline and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      prow_q       <= 8'd0;
      pcol_q       <= 8'd0;
      r_row_q      <= 8'd0;
      r_col_q      <= 8'd0;
      sta_q        <= 1'b0;
      stb_q        <= 1'b0;
      stb_row_q    <= 8'd0;
      stb_col_q    <= 8'd0;
      rd_ptr_q     <= PW'(0);
      wr_ptr_q     <= PW'(0);
      count_q      <= CW'(0);
      ch_out_q     <= 8'd0;
      ch_row_q     <= 8'd0;
      ch_col_q     <= 8'd0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
      ch_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prow_q       <= prow_d;
      pcol_q       <= pcol_d;
      r_row_q      <= r_row_d;
      r_col_q      <= r_col_d;
      sta_q        <= sta_d;
      stb_q        <= sta_q;
      stb_row_q    <= r_row_q;
      stb_col_q    <= r_col_q;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      ch_out_q     <= ch_out_d;
      ch_row_q     <= ch_row_d;
      ch_col_q     <= ch_col_d;
      eol_q        <= eol_d;
      eof_q        <= eof_d;
      ch_valid_q   <= ch_valid_d;
      busy_q       <= (state_d != S_IDLE);
      frame_done_q <= frame_done_d;
    end
  end

  // FIFO storage, written from pipeline stage B.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_ch_q[i]  <= 8'd0;
        mem_row_q[i] <= 8'd0;
        mem_col_q[i] <= 8'd0;
      end
    end else if (push_s) begin
      mem_ch_q[wr_ptr_q]  <= a_out;
      mem_row_q[wr_ptr_q] <= stb_row_q;
      mem_col_q[wr_ptr_q] <= stb_col_q;
    end else begin
      mem_ch_q[wr_ptr_q]  <= mem_ch_q[wr_ptr_q];
    end
  end

  assign r_row      = r_row_q;
  assign r_col      = r_col_q;
  assign ch_out     = ch_out_q;
  assign ch_row     = ch_row_q;
  assign ch_col     = ch_col_q;
  assign eol        = eol_q;
  assign eof        = eof_q;
  assign ch_valid   = ch_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
